// File: rtl/iec_drive_pkg.sv
// Shared types and constants for the IEC drive subsystem block-device path.
package iec_drive_pkg;

    localparam int MAX_DRIVES = 4;

    typedef logic [31:0] lba_t;
    typedef logic [5:0]  blkcnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    // Limit the requested drive count to what the 2-bit drive index can address.
    function automatic int clamp_drives(input int drives);
        if (drives < 1) begin
            clamp_drives = 1;
        end else if (drives > MAX_DRIVES) begin
            clamp_drives = MAX_DRIVES;
        end else begin
            clamp_drives = drives;
        end
    endfunction

endpackage

// File: rtl/iec_sd_arbiter_rr_pick.sv
// Round-robin priority encoder: first pending index strictly after 'last', with wrap.
module rr_pick
    import iec_drive_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand_s;

    // Scan farthest candidate first so the nearest successor of 'last' overwrites it.
    always_comb begin
        idx    = 2'd0;
        cand_s = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_s = last + 2'(k) + 2'd1;
            idx    = pending[cand_s] ? cand_s : idx;
        end
        valid = |pending;
    end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter folding the per-drive block request channels onto the single
// host SD block channel, with ack/write-data routing and a REQ watchdog.
module iec_sd_arbiter
    import iec_drive_pkg::*;
#(
    parameter int          DRIVES  = 2,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000,
    localparam int         NDR     = clamp_drives(DRIVES),
    localparam int         N       = NDR - 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] drv_lba [NDR],
    input  logic [5:0]  drv_blk_cnt [NDR],
    input  logic [N:0]  drv_rd,
    input  logic [N:0]  drv_wr,
    output logic [N:0]  drv_ack,
    input  logic [7:0]  drv_buff_din [NDR],
    output logic [31:0] sd_lba,
    output logic [5:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    output logic [7:0]  sd_buff_din,
    output logic        busy,
    output logic [1:0]  cur_drive,
    output logic        timeout_err
);

    arb_state_t  state_r;
    logic [1:0]  last_r;
    logic [1:0]  cur_drive_r;
    lba_t        lba_r;
    blkcnt_t     blk_cnt_r;
    logic        op_rd_r;
    logic        sd_rd_r;
    logic        sd_wr_r;
    logic [N:0]  drv_ack_r;
    logic        busy_r;
    logic        timeout_err_r;
    logic [23:0] wd_r;

    lba_t        lba_pad_s [4];
    blkcnt_t     blk_pad_s [4];
    logic [7:0]  din_pad_s [4];
    logic [3:0]  rd_pad_s;
    logic [3:0]  wr_pad_s;
    logic [N:0]  ack_sel_s;
    logic [1:0]  pick_idx_s;
    logic        pick_valid_s;
    logic        req_held_s;

    // Absent drive slots read as idle so the picker and muxes can always work on 4 lanes.
    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < NDR) begin : g_on
            assign lba_pad_s[g] = drv_lba[g];
            assign blk_pad_s[g] = drv_blk_cnt[g];
            assign din_pad_s[g] = drv_buff_din[g];
            assign rd_pad_s[g]  = drv_rd[g];
            assign wr_pad_s[g]  = drv_wr[g];
        end else begin : g_off
            assign lba_pad_s[g] = 32'd0;
            assign blk_pad_s[g] = 6'd0;
            assign din_pad_s[g] = 8'd0;
            assign rd_pad_s[g]  = 1'b0;
            assign wr_pad_s[g]  = 1'b0;
        end
    end

    for (genvar g = 0; g < NDR; g++) begin : g_ack
        assign ack_sel_s[g] = (cur_drive_r == 2'(g));
    end

    rr_pick u_rr_pick (
        .pending (rd_pad_s | wr_pad_s),
        .last    (last_r),
        .idx     (pick_idx_s),
        .valid   (pick_valid_s)
    );

    assign req_held_s = op_rd_r ? rd_pad_s[cur_drive_r] : wr_pad_s[cur_drive_r];

    // Arbitration FSM; every host-facing output is a register updated here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_r        <= 2'(N);
            cur_drive_r   <= 2'd0;
            lba_r         <= 32'd0;
            blk_cnt_r     <= 6'd0;
            op_rd_r       <= 1'b0;
            sd_rd_r       <= 1'b0;
            sd_wr_r       <= 1'b0;
            drv_ack_r     <= {(N+1){1'b0}};
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            wd_r          <= 24'd0;
        end else begin
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    drv_ack_r <= {(N+1){1'b0}};
                    if (pick_valid_s) begin
                        cur_drive_r <= pick_idx_s;
                        lba_r       <= lba_pad_s[pick_idx_s];
                        blk_cnt_r   <= blk_pad_s[pick_idx_s];
                        op_rd_r     <= rd_pad_s[pick_idx_s];
                        sd_rd_r     <= rd_pad_s[pick_idx_s];
                        sd_wr_r     <= ~rd_pad_s[pick_idx_s];
                        wd_r        <= 24'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_REQ;
                    end else begin
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        sd_rd_r   <= 1'b0;
                        sd_wr_r   <= 1'b0;
                        drv_ack_r <= ack_sel_s;
                        state_r   <= ST_XFER;
                    end else if (!req_held_s) begin
                        sd_rd_r   <= 1'b0;
                        sd_wr_r   <= 1'b0;
                        state_r   <= ST_GAP;
                    end else if (wd_r == (TIMEOUT - 24'd1)) begin
                        sd_rd_r       <= 1'b0;
                        sd_wr_r       <= 1'b0;
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_GAP;
                    end else begin
                        wd_r <= (wd_r == 24'hFF_FFFF) ? wd_r : wd_r + 24'd1;
                    end
                end
                ST_XFER: begin
                    drv_ack_r <= sd_ack ? ack_sel_s : {(N+1){1'b0}};
                    state_r   <= sd_ack ? ST_XFER : ST_GAP;
                end
                ST_GAP: begin
                    last_r  <= cur_drive_r;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sd_lba      = lba_r;
    assign sd_blk_cnt  = blk_cnt_r;
    assign sd_rd       = sd_rd_r;
    assign sd_wr       = sd_wr_r;
    assign drv_ack     = drv_ack_r;
    assign busy        = busy_r;
    assign cur_drive   = cur_drive_r;
    assign timeout_err = timeout_err_r;
    assign sd_buff_din = din_pad_s[cur_drive_r];

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Directed bench for iec_sd_arbiter (2 drives, short watchdog) with a grant scoreboard.
module tb_iec_sd_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] drv_lba [2];
    logic [5:0]  drv_blk_cnt [2];
    logic [1:0]  drv_rd;
    logic [1:0]  drv_wr;
    logic [1:0]  drv_ack;
    logic [7:0]  drv_buff_din [2];
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_din;
    logic        busy;
    logic [1:0]  cur_drive;
    logic        timeout_err;

    always #5 clk_sys = ~clk_sys;

    iec_sd_arbiter #(.DRIVES(2), .TIMEOUT(24'd16)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_din (drv_buff_din),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .cur_drive    (cur_drive),
        .timeout_err  (timeout_err)
    );

    typedef struct packed {
        logic [1:0]  drv;
        logic [31:0] lba;
        logic [5:0]  blk;
        logic        rd;
    } grant_t;

    grant_t sb_q[$];
    int     checks_cnt = 0;
    int     errors_cnt = 0;
    int     lat;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        assert (obs === exp) else begin
            errors_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int drv, input logic rd);
        grant_t g;
        g.drv = 2'(drv);
        g.lba = drv_lba[drv];
        g.blk = drv_blk_cnt[drv];
        g.rd  = rd;
        sb_q.push_back(g);
    endtask

    task automatic wait_grant(output int ticks);
        grant_t g;
        bit     seen;
        seen  = 1'b0;
        ticks = 0;
        while (!seen && ticks < 20) begin
            tick();
            ticks++;
            seen = sd_rd | sd_wr;
        end
        check("grant_seen", 32'(seen), 32'd1);
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            g = sb_q.pop_front();
            check("grant_drive", 32'(cur_drive), 32'(g.drv));
            check("grant_lba", sd_lba, g.lba);
            check("grant_blk", 32'(sd_blk_cnt), 32'(g.blk));
            check("grant_sd_rd", 32'(sd_rd), 32'(g.rd));
            check("grant_sd_wr", 32'(sd_wr), 32'(!g.rd));
            check("grant_busy", 32'(busy), 32'd1);
        end
    endtask

    // Host acknowledges for len cycles; the drive withdraws its request on ack when drop is set.
    task automatic host_xfer(input int drv, input int len, input bit drop);
        sd_ack = 1'b1;
        if (drop) begin
            drv_rd[drv] = 1'b0;
            drv_wr[drv] = 1'b0;
        end
        for (int k = 0; k < len; k++) begin
            tick();
            check("drv_ack_hi", 32'(drv_ack), 32'd1 << drv);
            check("sd_req_drop", 32'({sd_rd, sd_wr}), 32'd0);
            check("buff_din", 32'(sd_buff_din), 32'(drv_buff_din[drv]));
        end
        sd_ack = 1'b0;
        tick();
        check("drv_ack_lo", 32'(drv_ack), 32'd0);
        check("busy_gap", 32'(busy), 32'd1);
        tick();
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        check("rst_sd_blk", 32'(sd_blk_cnt), 32'd0);
        check("rst_drv_ack", 32'(drv_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_drive", 32'(cur_drive), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        sd_ack = 1'b0;
        drv_rd = 2'b00;
        drv_wr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            drv_lba[i]      = 32'd0;
            drv_blk_cnt[i]  = 6'd0;
            drv_buff_din[i] = 8'd0;
        end
        tick();
        tick();
        check_reset();
        reset = 1'b0;

        // Single read on drive 0 with a long transfer.
        drv_lba[0]      = 32'd357;
        drv_blk_cnt[0]  = 6'd0;
        drv_buff_din[0] = 8'h11;
        drv_rd[0]       = 1'b1;
        expect_grant(0, 1'b1);
        wait_grant(lat);
        check("read_latency", 32'(lat), 32'd1);
        host_xfer(0, 512, 1'b1);

        // Round-robin between a held read on 0 and a held write on 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drv_lba[0]      = 32'd100;
        drv_lba[1]      = 32'd200;
        drv_blk_cnt[1]  = 6'd7;
        drv_buff_din[1] = 8'h5A;
        drv_rd[0]       = 1'b1;
        drv_wr[1]       = 1'b1;
        expect_grant(0, 1'b1);
        expect_grant(1, 1'b0);
        expect_grant(0, 1'b1);
        expect_grant(1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            wait_grant(lat);
            for (int k = 0; k < 4; k++) begin
                tick();
                check("rr_req_hold", 32'(sd_rd | sd_wr), 32'd1);
            end
            if (r == 3) begin
                drv_rd[0] = 1'b0;
            end
            host_xfer(r % 2, 3, r == 3);
        end

        // Read wins over write on the same drive; drive 1 write data is routed.
        drv_lba[1]      = 32'h0000_2222;
        drv_blk_cnt[1]  = 6'd63;
        drv_buff_din[1] = 8'hA5;
        drv_buff_din[0] = 8'h3C;
        drv_rd[1]       = 1'b1;
        drv_wr[1]       = 1'b1;
        expect_grant(1, 1'b1);
        wait_grant(lat);
        check("prio_buff_req", 32'(sd_buff_din), 32'hA5);
        host_xfer(1, 4, 1'b1);

        // Watchdog: write request never acknowledged.
        drv_lba[0]     = 32'hDEAD_BEEF;
        drv_blk_cnt[0] = 6'd5;
        drv_wr[0]      = 1'b1;
        expect_grant(0, 1'b0);
        wait_grant(lat);
        for (int k = 0; k < 15; k++) begin
            tick();
            check("wd_req_held", 32'(sd_wr), 32'd1);
            check("wd_no_err", 32'(timeout_err), 32'd0);
        end
        tick();
        check("wd_err_pulse", 32'(timeout_err), 32'd1);
        check("wd_req_drop", 32'(sd_wr), 32'd0);
        check("wd_busy_gap", 32'(busy), 32'd1);
        tick();
        check("wd_err_once", 32'(timeout_err), 32'd0);
        check("wd_busy_idle", 32'(busy), 32'd0);
        expect_grant(0, 1'b0);
        wait_grant(lat);
        check("wd_regrant_latency", 32'(lat), 32'd1);

        // Reset during XFER with the host still acknowledging.
        sd_ack = 1'b1;
        tick();
        check("rst_mid_xfer_ack", 32'(drv_ack), 32'd1);
        reset     = 1'b1;
        drv_rd[1] = 1'b1;
        tick();
        check_reset();
        reset  = 1'b0;
        sd_ack = 1'b0;
        expect_grant(0, 1'b0);
        expect_grant(1, 1'b1);
        wait_grant(lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        host_xfer(0, 2, 1'b1);
        wait_grant(lat);
        host_xfer(1, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/iec_sd_arbiter.md
# iec_sd_arbiter

Multiplexes the per-drive block-device request channels of the IEC drive subsystem (up to 4 drives, each with its own LBA, block count, read and write strobes) onto the single SD block channel of the host I/O core. Sits directly downstream of the drive selector. Picks one drive at a time using round-robin order, presents that drive's request to the host and routes the acknowledge and write-data bytes back to the owning drive. A watchdog recovers from host requests that are never acknowledged.

## Interface
Parameters:
- DRIVES, 2, number of drive channels; clamped internally to NDR = 1..4, N = NDR-1
- TIMEOUT, 24'd10_000_000, clk_sys cycles allowed in REQ without sd_ack before abort

Ports:
- clk_sys  in  1  system clock; only clock
- reset  in  1  synchronous, active-high
- drv_lba[NDR]  in  32  per-drive LBA
- drv_blk_cnt[NDR]  in  6  per-drive block count minus one
- drv_rd  in  N+1  per-drive read request, level, held until ack
- drv_wr  in  N+1  per-drive write request, level, held until ack
- drv_ack  out  N+1  per-drive acknowledge (one-hot or zero)
- drv_buff_din[NDR]  in  8  per-drive write-data byte
- sd_lba  out  32  host LBA
- sd_blk_cnt  out  6  host block count
- sd_rd  out  1  host read request
- sd_wr  out  1  host write request
- sd_ack  in  1  host acknowledge, high for the whole transfer
- sd_buff_din  out  8  write-data byte to host
- busy  out  1  high in any state other than IDLE
- cur_drive  out  2  index of the granted drive
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
States: IDLE, REQ, XFER, GAP.
- **IDLE**
  - Pending vector: p[i] = drv_rd[i] | drv_wr[i].
  - If any p is set, grant the first set index searching from (last+1) mod NDR upward with wrap.
  - On grant, latch into registers: index to cur_drive, lba, blk_cnt, and op. Op is read if drv_rd[i] is high, otherwise write; a read wins when both are high.
  - Go to REQ.
- **REQ**
  - sd_rd or sd_wr = latched op. sd_lba and sd_blk_cnt come from the latched registers.
  - If sd_ack is high: drop sd_rd/sd_wr, go to XFER.
  - Else if the granted drive's latched op request is low (withdrawn): go to GAP, no ack issued.
  - Else if the watchdog reaches TIMEOUT-1: pulse timeout_err, go to GAP.
- **XFER**
  - drv_ack[cur_drive] = sd_ack; all other drv_ack bits are 0.
  - When sd_ack falls, go to GAP.
- **GAP**
  - One cycle. Set last = cur_drive, go to IDLE.
  - The gap lets the drive see its ack drop before the arbiter re-samples requests.
- **Data path**
  - sd_buff_din = drv_buff_din[cur_drive], combinational mux. Valid in every state and held through XFER.
- **Watchdog**
  - 24-bit counter. Cleared on entry to REQ; increments each REQ cycle. Saturates, never wraps.
- **Stable registers**
  - last, cur_drive and the latched lba/blk_cnt/op do not change outside the IDLE grant.

## Timing
- **Reset values**
  - sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, drv_ack=0, busy=0, cur_drive=0, timeout_err=0.
  - last=N, so the first search starts at drive 0. State=IDLE.
- **Reset mid-transfer:** all of the above take effect the following cycle; an active sd_ack is then ignored.
- **Request latency:** drv_rd sampled high in IDLE at cycle t gives sd_rd=1 at t+1 (registered outputs).
- **Ack path:** sd_ack high at cycle t (in REQ) gives sd_rd=0 and state XFER at t+1; drv_ack is high from t+1. drv_ack follows sd_ack with 1 cycle of latency throughout.
- **Ack fall:** sd_ack low at t gives drv_ack low at t+1, GAP at t+1, IDLE at t+2.
- **Re-sampling:** requests are sampled in IDLE earliest at t+2.
- **Minimum spacing:** 4 cycles between two grants.
- **Simultaneous requests:** requests arriving in the same cycle are served in round-robin order. One drive cannot be served twice in a row while another is pending.
- **NDR=1:** arbitration collapses to always grant 0.

## Structure
- Shared package iec_drive_pkg:
  - state enum (IDLE, REQ, XFER, GAP)
  - MAX_DRIVES=4
  - typedef lba_t (32-bit)
  - typedef blkcnt_t (6-bit)
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs are pending[3:0] and last[1:0]; outputs are the index and valid.
- Everything else lives in iec_sd_arbiter.

## Test plan
- **Single read:** NDR=2, reset, drv_rd[0]=1, drv_lba[0]=357, drv_blk_cnt[0]=0. Required: sd_rd=1 and sd_lba=357 one cycle later. Host raises sd_ack for 512 cycles. Required: drv_ack[0] mirrors sd_ack delayed by one cycle, sd_rd drops the cycle after ack, busy falls 2 cycles after ack falls.
- **Round-robin:** drv_rd[0] and drv_wr[1] both held high, host acks each request after 5 cycles. Required grant order 0,1,0,1; sd_wr=1 while cur_drive=1.
- **Read/write priority:** drv_rd[1]=drv_wr[1]=1 on the same cycle. Required: sd_rd=1, sd_wr=0.
- **Write data routing:** drv_buff_din[1]=8'hA5, drv_buff_din[0]=8'h3C, drive 1 granted. Required: sd_buff_din=8'hA5 throughout XFER.
- **Watchdog:** TIMEOUT=16, request with no sd_ack. Required: timeout_err pulses once at REQ cycle 16, then IDLE. The still-held request is re-granted after GAP.
- **Reset mid-transfer:** reset asserted during XFER with sd_ack=1. Required: all outputs at reset values the next cycle. After reset release, the first grant goes to drive 0.
